// File: rtl/f2h_avmm_arbiter_pkg.sv
// f2h_arb_pkg
// Shared definitions for the F2H Avalon-MM arbiter slice:
//   arb_state_t     - arbitration FSM states (ARB picks a winner, ISSUE drives it)
//   ERR_*           - bit positions inside err_sticky
//   DEF_*           - default parameter values used by the interface and modules
package f2h_arb_pkg;

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      ISSUE = 1'b1
   } arb_state_t;

   localparam int ERR_EMPTY_RDV = 0;
   localparam int ERR_WR_RD     = 1;

   localparam int DEF_NUM_REQ   = 2;
   localparam int DEF_DATA_W    = 512;
   localparam int DEF_ADDR_W    = 64;
   localparam int DEF_MAX_OUTST = 8;

endpackage

// File: rtl/f2h_avmm_arbiter_if.sv
// f2h_avmm_arbiter_if
// Avalon-MM bundle carrying NUM_PORTS agents side by side. Per-agent fields are
// packed with agent i at [i*W +: W]; readdata is a single broadcast bus.
// The requester side uses NUM_PORTS=NUM_REQ, the F2H bridge side NUM_PORTS=1.
//   master modport : drives write/read/address/byteenable/writedata,
//                    receives waitrequest/readdatavalid/readdata
//   slave  modport : the mirror image
interface f2h_avmm_arbiter_if
   import f2h_arb_pkg::*;
#(
   parameter int NUM_PORTS = 1,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W
) ();

   logic [NUM_PORTS-1:0]          avmm_write;
   logic [NUM_PORTS-1:0]          avmm_read;
   logic [NUM_PORTS*ADDR_W-1:0]   avmm_address;
   logic [NUM_PORTS*DATA_W/8-1:0] avmm_byteenable;
   logic [NUM_PORTS*DATA_W-1:0]   avmm_writedata;
   logic [NUM_PORTS-1:0]          avmm_waitrequest;
   logic [NUM_PORTS-1:0]          avmm_readdatavalid;
   logic [DATA_W-1:0]             avmm_readdata;

   modport master (
      output avmm_write, avmm_read, avmm_address, avmm_byteenable, avmm_writedata,
      input  avmm_waitrequest, avmm_readdatavalid, avmm_readdata
   );

   modport slave (
      input  avmm_write, avmm_read, avmm_address, avmm_byteenable, avmm_writedata,
      output avmm_waitrequest, avmm_readdatavalid, avmm_readdata
   );

endinterface

// File: rtl/f2h_avmm_arbiter_id_fifo.sv
// f2h_arb_id_fifo
// Synchronous FIFO holding the requester index of every read in flight.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   clk, rst_n       : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data  : enqueue (ignored when full)
//   pop              : dequeue (ignored when empty)
//   head             : oldest entry, valid when !empty
//   full, empty      : status
//   count            : number of stored entries (0..DEPTH)
module f2h_arb_id_fifo
   import f2h_arb_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUTST,
   parameter int WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/f2h_avmm_arbiter.sv
// f2h_avmm_arbiter
// Round-robin arbiter sharing the single F2H Avalon-MM master port between
// NUM_REQ requesters. Commands are serialised through a two-state FSM
// (ARB picks a winner, ISSUE holds it until the bridge accepts). Each accepted
// read pushes its requester index into an ID FIFO so returning beats are
// steered back in order with zero latency.
//   clk, rst_n   : clock, synchronous active-low reset
//   req          : requester-facing bundle (slave side, NUM_REQ agents)
//   f2h          : bridge-facing bundle (master side, single agent)
//   outstanding  : reads in flight
//   err_sticky   : [0] readdatavalid with no read in flight,
//                  [1] a requester asserted write and read together
module f2h_avmm_arbiter
   import f2h_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MAX_OUTST = DEF_MAX_OUTST
) (
   input  logic                       clk,
   input  logic                       rst_n,
   f2h_avmm_arbiter_if.slave          req,
   f2h_avmm_arbiter_if.master         f2h,
   output logic [$clog2(MAX_OUTST):0] outstanding,
   output logic [1:0]                 err_sticky
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int BE_W = DATA_W / 8;

   arb_state_t         state;
   arb_state_t         state_next;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    ptr_next;
   logic [NUM_REQ-1:0] eligible;
   logic               any_elig;
   int                 rr_idx;

   logic               grant_wr;
   logic               grant_rd;
   logic               accept;
   logic               push;
   logic               pop;
   logic [ID_W-1:0]    fifo_head;
   logic               fifo_full;
   logic               fifo_empty;

   // A read is only eligible while there is room to remember who issued it.
   assign eligible = req.avmm_write | (req.avmm_read & {NUM_REQ{~fifo_full}});

   // Scan from rr_ptr upward with wrap; the first eligible requester wins.
   always_comb begin
      winner   = '0;
      any_elig = 1'b0;
      rr_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!any_elig && eligible[rr_idx]) begin
            winner   = ID_W'(rr_idx);
            any_elig = 1'b1;
         end
      end
   end

   assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ARB;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         state <= state_next;
         if (state == ARB && any_elig) begin
            grant_idx <= winner;
            rr_ptr    <= ptr_next;
         end
      end
   end

   // Write takes priority when a requester raises both strobes.
   assign grant_wr = req.avmm_write[grant_idx];
   assign grant_rd = req.avmm_read[grant_idx] & ~grant_wr;

   always_comb begin
      state_next           = state;
      f2h.avmm_write       = 1'b0;
      f2h.avmm_read        = 1'b0;
      req.avmm_waitrequest = '1;
      accept               = 1'b0;
      unique case (state)
         ARB: begin
            if (any_elig) state_next = ISSUE;
         end
         ISSUE: begin
            f2h.avmm_write = grant_wr;
            f2h.avmm_read  = grant_rd;
            if (!f2h.avmm_waitrequest) begin
               accept                          = 1'b1;
               req.avmm_waitrequest[grant_idx] = 1'b0;
               state_next                      = ARB;
            end
         end
         default: state_next = ARB;
      endcase
   end

   // grant_idx is frozen in ISSUE, so these stay stable while the bridge stalls.
   assign f2h.avmm_address    = req.avmm_address[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign f2h.avmm_byteenable = req.avmm_byteenable[int'(grant_idx)*BE_W +: BE_W];
   assign f2h.avmm_writedata  = req.avmm_writedata[int'(grant_idx)*DATA_W +: DATA_W];
   assign req.avmm_readdata   = f2h.avmm_readdata;

   assign push = accept & grant_rd;
   assign pop  = f2h.avmm_readdatavalid & ~fifo_empty;

   f2h_arb_id_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (grant_idx),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding)
   );

   always_comb begin
      req.avmm_readdatavalid = '0;
      if (pop) req.avmm_readdatavalid[fifo_head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky <= '0;
      end else begin
         if (f2h.avmm_readdatavalid && fifo_empty)
            err_sticky[ERR_EMPTY_RDV] <= 1'b1;
         if (accept && grant_wr && req.avmm_read[grant_idx])
            err_sticky[ERR_WR_RD] <= 1'b1;
      end
   end

endmodule

// File: doc/f2h_avmm_arbiter.md
# f2h_avmm_arbiter

Round-robin arbiter sharing the single 512-bit F2H Avalon-MM master port between NUM_REQ requesting agents (e.g. the f2h interface tester plus a DMA/test agent). Sits between the requesting agents and the F2H bridge. Serialises write and read commands and tracks outstanding reads in an ID FIFO. Steers each returning readdatavalid to the requester that issued the read.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 512, data width
- ADDR_W, 64, address width
- MAX_OUTST, 8, max outstanding reads (power of 2, ID FIFO depth)

Ports:
- clk  in  1  single clock; all logic synchronous to it
- rst_n  in  1  reset, synchronous, active-low
- req_avmm_write  in  NUM_REQ  per-requester write
- req_avmm_read  in  NUM_REQ  per-requester read
- req_avmm_address  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_avmm_byteenable  in  NUM_REQ*DATA_W/8  packed
- req_avmm_writedata  in  NUM_REQ*DATA_W  packed
- req_avmm_waitrequest  out  NUM_REQ  per-requester stall
- req_avmm_readdatavalid  out  NUM_REQ  per-requester return strobe
- req_avmm_readdata  out  DATA_W  broadcast read data
- f2h_avmm_write / f2h_avmm_read  out  1  command to F2H bridge
- f2h_avmm_address  out  ADDR_W
- f2h_avmm_byteenable  out  DATA_W/8
- f2h_avmm_writedata  out  DATA_W
- f2h_avmm_waitrequest  in  1
- f2h_avmm_readdatavalid  in  1
- f2h_avmm_readdata  in  DATA_W
- outstanding  out  $clog2(MAX_OUTST)+1  reads in flight
- err_sticky  out  2  [0] readdatavalid with empty FIFO; [1] requester asserted write and read together. Cleared only by reset.

## Operation
- FSM states:
  - ARB: if any eligible request, register winner into grant_idx and go to ISSUE. Otherwise stay in ARB.
  - ISSUE: drive the f2h_avmm command from requester grant_idx. When f2h_avmm_waitrequest=0, the command is accepted: deassert the requester's waitrequest that cycle and return to ARB.
- Eligible requester: write=1, or read=1 with ID FIFO not full.
  - A read while the FIFO is full is not granted; that requester stays stalled.
- Round-robin: search starts at last grant+1 modulo NUM_REQ. After reset the search starts at requester 0.
- Requester with write=1 and read=1 together: the write is issued, the read is ignored, and err_sticky[1] is set.
- Read accept: push grant_idx into the ID FIFO.
- f2h_avmm_readdatavalid=1:
  - Pop the FIFO head and assert req_avmm_readdatavalid[head] the same cycle (combinational).
  - If the FIFO is empty: drop the beat and set err_sticky[0].
- Push and pop in the same cycle are both performed; outstanding is unchanged.
- Push is gated by not-full evaluated at arbitration, so full blocks a new read grant even if a pop occurs that cycle.
- req_avmm_readdata = f2h_avmm_readdata always.
- Sync reset mid-transaction: FSM goes to ARB, FIFO empties, outstanding=0. Reads in flight across reset return with an empty FIFO and set err_sticky[0]; software quiesces the block first.

## Timing
- Reset values:
  - f2h_avmm_write/read=0, req_avmm_waitrequest all 1, req_avmm_readdatavalid all 0.
  - outstanding=0, err_sticky=0, grant pointer=0.
- req_avmm_waitrequest[i]=0 only in ISSUE, with grant_idx=i and f2h_avmm_waitrequest=0. Otherwise 1.
- Command latency: request first seen in ARB at cycle N; command on F2H at N+1; accepted at N+1 at the earliest. Peak throughput is 1 command per 2 cycles.
- F2H command signals are held stable while f2h_avmm_waitrequest=1, as Avalon-MM requires. The grant never changes in ISSUE.
- Read return: 0-cycle latency from f2h_avmm_readdatavalid to the requester. Responses come back in order.
- outstanding updates the cycle after a push or pop.

## Structure
- Package f2h_arb_pkg: FSM state enum {ARB, ISSUE}, err bit index constants, default parameter constants.
- Sub-module f2h_arb_id_fifo: MAX_OUTST x $clog2(NUM_REQ) synchronous FIFO with full, empty and count outputs. Wrap-around pointers carry one extra bit.
- Round-robin priority logic stays inline in the top module.

## Test plan
- Req0 write addr 0x0C64 data 0xDEAFDEAD, f2h_avmm_waitrequest held 1 for 10 cycles -> F2H command stable all 10 cycles; req_avmm_waitrequest[0] drops exactly on the accept cycle.
- Req0 and req1 both write continuously -> grants alternate 0,1,0,1; each command appears on F2H one cycle after its ARB cycle.
- Req0 reads 0x0666, then req1 reads 0x0C40; bridge returns 0xA0.., then 0xABAB.. -> readdatavalid[0] for the first beat, readdatavalid[1] for the second; outstanding goes 1,2,1,0.
- 8 reads issued with no returns -> outstanding=8; a ninth read is stalled while a concurrent write from the other requester is granted. One return -> the ninth read is granted.
- f2h_avmm_readdatavalid with outstanding=0 -> no requester strobe, err_sticky=2'b01. Then rst_n=0 for one cycle -> err_sticky=0 and all outputs at their reset values.
- Req1 asserts write and read with data 0xACAC0505 -> only the write is issued and err_sticky[1]=1.
